// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM stage of the pipeline.
// Accepts one load/store at a time, waits LATENCY cycles, then performs the
// access. It holds the pipeline with `stall` while the access is in flight.
// `readdata` holds the last loaded doubleword; it is the `dmemout` value.
// Optional feature macro: DMEM_BYTE_ACCESS_EN. When it is defined, size=1
// selects a byte access at any alignment. Otherwise all accesses are doublewords.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [63:0] address,
  input  logic [63:0] writedata,
  input  logic        size,
  output logic [63:0] readdata,
  output logic        readvalid,
  output logic        stall,
  output logic        misaligned
);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  is_load_q, is_load_d;
  logic                  is_byte_q, is_byte_d;
  logic [DEPTH_LOG2-1:0] index_q, index_d;
  logic [2:0]            lane_q, lane_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [63:0]           readdata_q, readdata_d;
  logic                  readvalid_q, readvalid_d;
  logic                  misaligned_q, misaligned_d;

  logic [63:0] mem_q [DEPTH];

  logic        req_s;
  logic        byte_req_s;
  logic        aligned_s;
  logic        mem_we_s;
  logic [63:0] mem_rd_s;
  logic [63:0] mem_wdata_s;
  logic [63:0] load_data_s;
  logic        unused_ok_s;

`ifdef DMEM_BYTE_ACCESS_EN
  assign byte_req_s  = size;
  assign unused_ok_s = ^address[63:DEPTH_LOG2+3];
`else
  assign byte_req_s  = 1'b0;
  assign unused_ok_s = ^{size, address[63:DEPTH_LOG2+3]};
`endif

  // A read with memwrite also high is treated as a store only.
  assign req_s     = memread | memwrite;
  assign aligned_s = byte_req_s | (address[2:0] == 3'd0);

  // The pipeline is held from acceptance until the access edge. It is released in DONE.
  assign stall = ((state_q == ST_IDLE) & req_s & aligned_s) | (state_q == ST_WAIT);

  assign readdata   = readdata_q;
  assign readvalid  = readvalid_q;
  assign misaligned = misaligned_q;

  // Form the stored word and the load result from the latched request.
  // A byte store merges one lane into the existing word.
  always_comb begin
    mem_rd_s    = mem_q[index_q];
    mem_wdata_s = wdata_q;
    load_data_s = mem_rd_s;
    if (is_byte_q) begin
      mem_wdata_s = mem_rd_s;
      mem_wdata_s[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      load_data_s = {56'd0, mem_rd_s[{lane_q, 3'b000} +: 8]};
    end else begin
      mem_wdata_s = wdata_q;
      load_data_s = mem_rd_s;
    end
  end

  // Compute the next state and the next output values.
  // Request fields are latched once, at acceptance, and used from then on.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_load_d    = is_load_q;
    is_byte_d    = is_byte_q;
    index_d      = index_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    readdata_d   = readdata_q;
    readvalid_d  = 1'b0;
    misaligned_d = 1'b0;
    mem_we_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s && aligned_s) begin
          is_load_d = memread & ~memwrite;
          is_byte_d = byte_req_s;
          index_d   = address[DEPTH_LOG2+2:3];
          lane_d    = address[2:0];
          wdata_d   = writedata;
          cnt_d     = CNT_INIT;
          state_d   = ST_WAIT;
        end else if (req_s) begin
          misaligned_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          mem_we_s    = ~is_load_q;
          readvalid_d = is_load_q;
          if (is_load_q) begin
            readdata_d = load_data_s;
          end else begin
            readdata_d = readdata_q;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register the control state and the outputs. Reset aborts any operation in flight.
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      is_load_q    <= 1'b0;
      is_byte_q    <= 1'b0;
      index_q      <= '0;
      lane_q       <= 3'd0;
      wdata_q      <= 64'd0;
      readdata_q   <= 64'd0;
      readvalid_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_load_q    <= is_load_d;
      is_byte_q    <= is_byte_d;
      index_q      <= index_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      readdata_q   <= readdata_d;
      readvalid_q  <= readvalid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Commit stores to the array. Reset is not applied to the array contents,
  // but a store does not commit at an edge where reset is asserted.
  always_ff @(posedge CLK) begin
    if (mem_we_s && resetl) begin
      mem_q[index_q] <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=2, DEPTH_LOG2=6).
// Expected responses are queued at issue time. A negedge monitor pops
// and compares them whenever readvalid or misaligned is presented.
module tb_dmem_responder;
  logic        CLK = 1'b0;
  logic        resetl;
  logic        memread;
  logic        memwrite;
  logic [63:0] address;
  logic [63:0] writedata;
  logic        size;
  logic [63:0] readdata;
  logic        readvalid;
  logic        stall;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_mis;
    logic [63:0] data;
  } exp_t;

  exp_t expq[$];

  dmem_responder #(.DEPTH_LOG2(6), .LATENCY(2)) dut (
    .CLK        (CLK),
    .resetl     (resetl),
    .memread    (memread),
    .memwrite   (memwrite),
    .address    (address),
    .writedata  (writedata),
    .size       (size),
    .readdata   (readdata),
    .readvalid  (readvalid),
    .stall      (stall),
    .misaligned (misaligned)
  );

  always #5 CLK = ~CLK;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest queued expectation.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (resetl === 1'b1 && (readvalid === 1'b1 || misaligned === 1'b1)) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_response readvalid=%b misaligned=%b required=none", readvalid, misaligned);
      end else begin
        e = expq.pop_front();
        check1("resp_misaligned", misaligned, e.is_mis);
        check1("resp_readvalid", readvalid, !e.is_mis);
        if (!e.is_mis) check64("resp_readdata", readdata, e.data);
      end
    end
  end

  // Present a request, count the stall cycles, then release the request after DONE.
  task automatic issue(input logic rd, input logic wr, input logic [63:0] a,
                       input logic [63:0] wd, input logic sz, input int exp_stall,
                       input string name);
    int n;
    n = 0;
    memread   = rd;
    memwrite  = wr;
    address   = a;
    writedata = wd;
    size      = sz;
    @(negedge CLK);
    while (stall === 1'b1 && n < 20) begin
      n++;
      @(negedge CLK);
    end
    check_int({name, "_stall_cycles"}, n, exp_stall);
    @(posedge CLK);
    #1;
    memread  = 1'b0;
    memwrite = 1'b0;
    size     = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic sz, input string name);
    issue(1'b0, 1'b1, a, d, sz, 3, name);
  endtask

  task automatic do_load(input logic [63:0] a, input logic sz, input logic [63:0] exp, input string name);
    exp_t e;
    e.is_mis = 1'b0;
    e.data   = exp;
    expq.push_back(e);
    issue(1'b1, 1'b0, a, 64'd0, sz, 3, name);
  endtask

  task automatic do_misaligned_load(input logic [63:0] a, input logic sz, input string name);
    exp_t e;
    e.is_mis = 1'b1;
    e.data   = 64'd0;
    expq.push_back(e);
    issue(1'b1, 1'b0, a, 64'd0, sz, 0, name);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    resetl    = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    address   = 64'd0;
    writedata = 64'd0;
    size      = 1'b0;

    // Reset state.
    @(posedge CLK);
    #1;
    resetl = 1'b1;
    @(negedge CLK);
    check64("reset_readdata", readdata, 64'd0);
    check1("reset_readvalid", readvalid, 1'b0);
    check1("reset_stall", stall, 1'b0);
    check1("reset_misaligned", misaligned, 1'b0);
    @(posedge CLK);
    #1;

    // Store then load a doubleword.
    do_store(64'h28, 64'h123456789abcdef0, 1'b0, "store_28");
    check64("store_keeps_readdata", readdata, 64'd0);
    do_load(64'h28, 1'b0, 64'h123456789abcdef0, "load_28");

    // Misaligned doubleword load: single pulse, no stall, readdata unchanged.
    do_misaligned_load(64'h2C, 1'b0, "mis_2c");
    check64("mis_readdata_held", readdata, 64'h123456789abcdef0);

    // Known contents at 0x30, then a store aborted by reset in cycle 1.
    do_store(64'h30, 64'h0, 1'b0, "store_30_zero");
    check64("store_readdata_held", readdata, 64'h123456789abcdef0);
    memwrite  = 1'b1;
    address   = 64'h30;
    writedata = 64'hF;
    @(negedge CLK);
    check1("abort_stall_c0", stall, 1'b1);
    @(posedge CLK);
    #1;
    resetl   = 1'b0;
    memwrite = 1'b0;
    @(posedge CLK);
    #1;
    resetl = 1'b1;
    @(negedge CLK);
    check64("abort_readdata", readdata, 64'd0);
    check1("abort_stall", stall, 1'b0);
    check1("abort_readvalid", readvalid, 1'b0);
    @(posedge CLK);
    #1;
    do_load(64'h30, 1'b0, 64'h0, "load_30_after_abort");

    // Index wrap: 0x200 maps to entry 0.
    do_store(64'h200, 64'hF, 1'b0, "store_200");
    do_load(64'h0, 1'b0, 64'hF, "load_0_wrap");

    // memread and memwrite together behave as a store only.
    issue(1'b1, 1'b1, 64'h38, 64'h55, 1'b0, 3, "both_38");
    do_load(64'h38, 1'b0, 64'h55, "load_38");

`ifdef DMEM_BYTE_ACCESS_EN
    do_store(64'h29, 64'hFFFFFFFFFFFFFFAB, 1'b1, "byte_store_29");
    do_load(64'h28, 1'b0, 64'h123456789abcabf0, "load_28_merged");
    do_load(64'h2F, 1'b1, 64'h12, "byte_load_2f");
`else
    do_misaligned_load(64'h2F, 1'b1, "size_ignored_2f");
    do_load(64'h28, 1'b0, 64'h123456789abcdef0, "load_28_again");
`endif

    repeat (4) @(posedge CLK);
    #1;
    check_int("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
